regfile_write_port: RTL
=======================

Name: regfile_write_port

Overview:
- Write-side counterpart of the register-file read-select path.
- Accepts write-back requests (address + data) through a valid/ready handshake and buffers them in a small in-order queue.
- Drains one request per cycle as a registered one-hot write-enable vector plus write data for the 32-entry register file.
- Publishes a pending-write bitmask so the read side and hazard logic can see registers whose writes are still in flight.

Parameters:
- DEPTH, 2, queue entries; must be a power of two, 2..8.
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width; the register count is 2^ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept; equals !full, combinational from count.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  write data.
- hold  in  1  stall drain (e.g. register file busy); the queue still accepts new requests.
- we  out  2^ADDR_W  registered one-hot write enable.
- wd  out  DATA_W  registered write data, paired with we.
- pending  out  2^ADDR_W  bit i set if register i is in the queue or in the we/wd stage.
- byp_addr  in  ADDR_W  bypass lookup address (see Optional Feature).
- byp_hit  out  1  bypass match.
- byp_data  out  DATA_W  newest in-flight data for byp_addr.

Behaviour:
- Reset (reset low, asynchronous):
  - Queue empties, count=0.
  - we=0, wd=0, pending=0, byp_hit=0, byp_data=0.
  - in_ready=1 while and after reset is low.
  - Entries in flight at reset are discarded; no write is emitted for them.
- Accept:
  - A request is accepted on a rising edge with in_valid & in_ready.
  - in_addr==0 is accepted but discarded: it is not enqueued and pending[0] stays 0.
  - No push occurs when full; in_ready does not depend on a same-cycle pop.
- Drain, evaluated at each rising edge:
  - If count>0 and !hold: we <= onehot(head.addr), wd <= head.data, pop head.
  - Otherwise: we <= 0 and wd holds its value.
- At most one bit of we is ever set, and we is high for exactly one cycle per drained entry.
- Latency: a request accepted at edge N into an empty queue with hold low drives we during the cycle after edge N+1. The register file commits it at edge N+2.
- Simultaneous push and pop at one edge is allowed when not full; count is unchanged.
- Ordering:
  - Strict FIFO.
  - Repeated writes to the same address are all emitted, in order.
  - The last write emitted for an address is the one accepted last.
- pending:
  - Combinational OR over onehot(addr) of the valid queue entries, plus the current we vector.
  - Drops for an address the cycle after its last write's we pulse.
- hold asserted mid-stream freezes the head with no loss or duplication. Deasserting hold resumes drain at the next edge.
- Full with hold high: in_ready=0 and requests stall upstream.
- Pointer wrap-around is modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.

Optional Feature:
- Macro: REGFILE_WRITE_PORT_BYPASS_EN.
- When defined, byp_hit/byp_data are combinational:
  - Search the valid queue entries from newest to oldest, then the we/wd stage.
  - The first entry whose address equals byp_addr gives byp_hit=1 and byp_data=that entry's data.
  - byp_addr==0 never hits.
- When undefined, the ports still exist and are tied byp_hit=0, byp_data=0. No comparison logic is built.

Test Plan:
- Release reset, push (addr 3, 0xDEADBEEF) with hold=0 -> we=0x00000008 and wd=0xDEADBEEF for exactly one cycle, two edges after acceptance; pending[3]=1 from acceptance until the cycle after we.
- hold=1, push addr 5 then addr 7 -> in_ready=0 after the second push; a third request stalls; pending=0x000000A0. Release hold -> we=0x20 then we=0x80 on consecutive cycles.
- Push (addr 9, 1) then (addr 9, 2) -> two pulses we=0x200 with wd=1 then wd=2; pending[9] clears only after the second pulse.
- Push addr 0 with data 0x1234 -> in_ready stays 1, we never asserts, pending=0.
- Fill the queue with hold=1, then drop reset low mid-stream -> we=0, pending=0 and in_ready=1 immediately (asynchronous); no writes after release.
- BYPASS_EN defined: queue holds (addr 4, 0xA) then (addr 4, 0xB), byp_addr=4 -> byp_hit=1, byp_data=0xB. byp_addr=0 -> byp_hit=0.

Source files
------------

// File: rtl/regfile_write_port.sv
// Register-file write port: in-order request queue draining one registered one-hot write per cycle.
// Define REGFILE_WRITE_PORT_BYPASS_EN to build the in-flight bypass lookup (byp_hit/byp_data).
module regfile_write_port #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     hold,
   output logic [(1<<ADDR_W)-1:0]   we,
   output logic [DATA_W-1:0]        wd,
   output logic [(1<<ADDR_W)-1:0]   pending,
   input  logic [ADDR_W-1:0]        byp_addr,
   output logic                     byp_hit,
   output logic [DATA_W-1:0]        byp_data
);

   localparam int NREG  = 1 << ADDR_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [NREG-1:0]   we_reg;
   logic [DATA_W-1:0] wd_reg;

   logic              push;
   logic              pop;
   logic [DEPTH-1:0]  entry_valid;
   logic [NREG-1:0]   entry_onehot [DEPTH];

   assign in_ready = (count_reg != CNT_W'(DEPTH));
   // Address 0 is handshaken but never enqueued.
   assign push     = in_valid && in_ready && (in_addr != '0);
   assign pop      = (count_reg != '0) && !hold;

   assign we = we_reg;
   assign wd = wd_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         we_reg    <= '0;
         wd_reg    <= '0;
      end else begin
         if (push)
            tail_reg <= tail_reg + PTR_W'(1);
         if (pop)
            head_reg <= head_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         if (pop) begin
            we_reg <= NREG'(1) << addr_mem[head_reg];
            wd_reg <= data_mem[head_reg];
         end else begin
            we_reg <= '0;
         end
      end
   end

   // Storage needs no reset: validity comes from head/count only.
   always_ff @(posedge clock) begin
      if (push) begin
         addr_mem[tail_reg] <= in_addr;
         data_mem[tail_reg] <= in_data;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [PTR_W-1:0] offset;
         assign offset          = PTR_W'(gi) - head_reg;
         assign entry_valid[gi] = ({1'b0, offset} < count_reg);
         assign entry_onehot[gi] = entry_valid[gi] ? (NREG'(1) << addr_mem[gi]) : '0;
      end
   endgenerate

   always_comb begin
      pending = we_reg;
      for (int i = 0; i < DEPTH; i++)
         pending = pending | entry_onehot[i];
   end

`ifdef REGFILE_WRITE_PORT_BYPASS_EN
   // Lowest priority first (we/wd stage, then oldest to newest) so the newest match wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      byp_hit  = 1'b0;
      byp_data = '0;
      idx      = '0;
      if (byp_addr != '0) begin
         if (we_reg[byp_addr]) begin
            byp_hit  = 1'b1;
            byp_data = wd_reg;
         end
         for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PTR_W'(k);
            if ((CNT_W'(k) < count_reg) && (addr_mem[idx] == byp_addr)) begin
               byp_hit  = 1'b1;
               byp_data = data_mem[idx];
            end
         end
      end
   end
`else
   logic unused_byp;
   assign unused_byp = ^byp_addr;
   assign byp_hit    = 1'b0;
   assign byp_data   = '0;
`endif

endmodule
